// File: rtl/button_field_control_pkg.sv
`default_nettype none
// ============================================================================
// Module  : button_field_control_pkg
// Brief   : Shared field indices, FSM state encoding and field-step helper
//           for the time/date adjustment front end.
// Revision: 1.0 - initial release
// ============================================================================
package button_field_control_pkg;

    // Field selector values seen by the downstream field counters
    localparam logic [3:0] FIELD_IDLE       = 4'd0;
    localparam logic [3:0] FIELD_SEC        = 4'd1;
    localparam logic [3:0] FIELD_MIN        = 4'd2;
    localparam logic [3:0] FIELD_HOUR       = 4'd3;
    localparam logic [3:0] FIELD_YEAR       = 4'd4;
    localparam logic [3:0] FIELD_MONTH      = 4'd5;
    localparam logic [3:0] FIELD_DAY        = 4'd6;
    localparam logic [3:0] FIELD_WEEKDAY    = 4'd7;
    localparam logic [3:0] FIELD_ALARM_HOUR = 4'd8;
    localparam logic [3:0] FIELD_ALARM_MIN  = 4'd9;
    localparam logic [3:0] FIELD_FIRST      = FIELD_SEC;

    // Field-selection FSM encoding
    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ADJUST = 1'b1
    } state_t;

    // Move one field forward or backward, wrapping between FIELD_FIRST and last
    function automatic logic [3:0] field_step(input logic [3:0] field,
                                              input logic       forward,
                                              input logic [3:0] last);
        if (forward) begin
            return (field >= last) ? FIELD_FIRST : field + 4'd1;
        end
        return (field <= FIELD_FIRST) ? last : field - 4'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/button_field_control_if.sv
`default_nettype none
// ============================================================================
// Module  : button_field_control_if
// Brief   : Raw button/switch inputs and field-control outputs of the
//           adjustment front end.
// Revision: 1.0 - initial release
// ============================================================================
interface button_field_control_if;
    logic       prog_sw;
    logic       btn_up;
    logic       btn_down;
    logic       btn_left;
    logic       btn_right;
    logic [3:0] en_count;
    logic       enUP;
    logic       enDOWN;

    // Driver of the buttons, consumer of the field controls
    modport master (
        output prog_sw, btn_up, btn_down, btn_left, btn_right,
        input  en_count, enUP, enDOWN
    );

    // The control block itself
    modport slave (
        input  prog_sw, btn_up, btn_down, btn_left, btn_right,
        output en_count, enUP, enDOWN
    );
endinterface
`default_nettype wire

// File: rtl/button_field_control_debounce_sync.sv
`default_nettype none
// ============================================================================
// Module  : debounce_sync
// Brief   : Two-flop synchronizer, counter debouncer and rising-edge decode
//           for one raw push-button or switch.
// Revision: 1.0 - initial release
// ============================================================================
module debounce_sync #(
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_raw,
    output logic o_level,
    output logic o_rise
);

    localparam int                 c_CNT_W    = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DB_CYCLES - 1);

    if (DB_CYCLES < 1) begin : g_bad_db_cycles
        $error("debounce_sync: DB_CYCLES must be at least 1");
    end

    logic               r_sync1;
    logic               r_sync2;
    logic               r_level;
    logic               r_level_d;
    logic [c_CNT_W-1:0] r_cnt;

    // Bring the asynchronous input into the clk domain
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Accept a new level only after DB_CYCLES consecutive differing samples
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else if (r_sync2 == r_level) begin
            r_cnt   <= '0;
        end else if (r_cnt == c_CNT_LAST) begin
            r_level <= r_sync2;
            r_cnt   <= '0;
        end else begin
            r_cnt   <= r_cnt + 1'b1;
        end
    end

    // One-cycle history of the debounced level for edge detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_level_d <= 1'b0;
        end else begin
            r_level_d <= r_level;
        end
    end

    // Both terms are flops, so the pulse is clean and exactly one cycle long
    assign o_level = r_level;
    assign o_rise  = r_level & ~r_level_d;

endmodule
`default_nettype wire

// File: rtl/button_field_control.sv
`default_nettype none
// ============================================================================
// Module  : button_field_control
// Brief   : Conditions the adjustment buttons and programming switch, selects
//           the field being adjusted and drives the up/down level enables.
// Revision: 1.0 - initial release
// ============================================================================
module button_field_control
    import button_field_control_pkg::*;
#(
    parameter int DB_CYCLES = 1_000_000,
    parameter int N_FIELDS  = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    button_field_control_if.slave bus
);

    localparam logic [3:0] c_LAST_FIELD = 4'(N_FIELDS);
    localparam int         c_IDX_PROG   = 0;
    localparam int         c_IDX_UP     = 1;
    localparam int         c_IDX_DOWN   = 2;
    localparam int         c_IDX_LEFT   = 3;
    localparam int         c_IDX_RIGHT  = 4;

    if (N_FIELDS < 1 || N_FIELDS > 15) begin : g_bad_n_fields
        $error("button_field_control: N_FIELDS must be in 1..15");
    end

    logic [4:0] w_raw;
    logic [4:0] w_level;
    logic [4:0] w_rise;
    logic       w_unused;

    assign w_raw = {bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up, bus.prog_sw};

    for (genvar gi = 0; gi < 5; gi++) begin : g_input
        debounce_sync #(
            .DB_CYCLES (DB_CYCLES)
        ) u_debounce (
            .clk     (clk),
            .reset   (reset),
            .i_raw   (w_raw[gi]),
            .o_level (w_level[gi]),
            .o_rise  (w_rise[gi])
        );
    end

    // Prog/up/down act as levels, left/right only as edges
    assign w_unused = ^{w_rise[c_IDX_DOWN:c_IDX_PROG], w_level[c_IDX_RIGHT:c_IDX_LEFT]};

    logic   w_prog;
    logic   w_up;
    logic   w_down;
    logic   w_left;
    logic   w_right;

    assign w_prog  = w_level[c_IDX_PROG];
    assign w_up    = w_level[c_IDX_UP];
    assign w_down  = w_level[c_IDX_DOWN];
    assign w_left  = w_rise[c_IDX_LEFT];
    assign w_right = w_rise[c_IDX_RIGHT];

    state_t     r_state;
    logic [3:0] r_field;
    logic       r_en_up;
    logic       r_en_down;

    // Field-selection FSM with registered selector and up/down enables
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_field   <= FIELD_IDLE;
            r_en_up   <= 1'b0;
            r_en_down <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_en_up   <= 1'b0;
                    r_en_down <= 1'b0;
                    if (w_prog) begin
                        r_state <= ST_ADJUST;
                        r_field <= FIELD_FIRST;
                    end else begin
                        r_field <= FIELD_IDLE;
                    end
                end
                ST_ADJUST: begin
                    if (!w_prog) begin
                        // Leaving adjust mode wins over any same-cycle step
                        r_state   <= ST_IDLE;
                        r_field   <= FIELD_IDLE;
                        r_en_up   <= 1'b0;
                        r_en_down <= 1'b0;
                    end else begin
                        if (w_right && !w_left) begin
                            r_field <= field_step(r_field, 1'b1, c_LAST_FIELD);
                        end else if (w_left && !w_right) begin
                            r_field <= field_step(r_field, 1'b0, c_LAST_FIELD);
                        end
                        r_en_up   <= w_up & ~w_down;
                        r_en_down <= w_down & ~w_up;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_field <= FIELD_IDLE;
                end
            endcase
        end
    end

    assign bus.en_count = r_field;
    assign bus.enUP     = r_en_up;
    assign bus.enDOWN   = r_en_down;

endmodule
`default_nettype wire

// File: tb/tb_button_field_control.sv
`default_nettype none
// ============================================================================
// Module  : tb_button_field_control
// Brief   : Self-checking bench for button_field_control with a cycle model
//           of the conditioning chain and field-selection rules.
// Revision: 1.0 - initial release
// ============================================================================
module tb_button_field_control;

    localparam int TB_DB = 4;
    localparam int TB_N  = 9;

    logic clk = 1'b0;
    logic reset;
    int   checks;
    int   failures;

    always #5 clk = ~clk;

    button_field_control_if bus();

    button_field_control #(
        .DB_CYCLES (TB_DB),
        .N_FIELDS  (TB_N)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // ------------------------------------------------------------------
    // Model: an input level is accepted once the value seen two edges late
    // has been the opposite of the current level for TB_DB edges in a row.
    // Index 0 prog, 1 up, 2 down, 3 left, 4 right.
    // ------------------------------------------------------------------
    bit m_h     [5][TB_DB+2];
    bit m_lvl   [5];
    bit m_lvl_d [5];
    bit m_adj;
    int m_field;
    bit m_up;
    bit m_dn;

    always @(posedge clk or negedge reset) begin
        logic [4:0] raw;
        bit         rise_l;
        bit         rise_r;
        bit         stable;
        if (!reset) begin
            for (int i = 0; i < 5; i++) begin
                for (int j = 0; j < TB_DB + 2; j++) m_h[i][j] = 1'b0;
                m_lvl[i]   = 1'b0;
                m_lvl_d[i] = 1'b0;
            end
            m_adj   = 1'b0;
            m_field = 0;
            m_up    = 1'b0;
            m_dn    = 1'b0;
        end else begin
            rise_l = m_lvl[3] && !m_lvl_d[3];
            rise_r = m_lvl[4] && !m_lvl_d[4];
            if (!m_adj) begin
                m_up = 1'b0;
                m_dn = 1'b0;
                if (m_lvl[0]) begin
                    m_adj   = 1'b1;
                    m_field = 1;
                end
            end else if (!m_lvl[0]) begin
                m_adj   = 1'b0;
                m_field = 0;
                m_up    = 1'b0;
                m_dn    = 1'b0;
            end else begin
                if (rise_r && !rise_l)      m_field = (m_field % TB_N) + 1;
                else if (rise_l && !rise_r) m_field = (m_field == 1) ? TB_N : m_field - 1;
                m_up = m_lvl[1] && !m_lvl[2];
                m_dn = m_lvl[2] && !m_lvl[1];
            end
            raw = {bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up, bus.prog_sw};
            for (int i = 0; i < 5; i++) begin
                for (int j = TB_DB + 1; j > 0; j--) m_h[i][j] = m_h[i][j-1];
                m_h[i][0] = raw[i];
                stable = 1'b1;
                for (int j = 2; j <= TB_DB + 1; j++) begin
                    if (m_h[i][j] == m_lvl[i]) stable = 1'b0;
                end
                m_lvl_d[i] = m_lvl[i];
                if (stable) m_lvl[i] = !m_lvl[i];
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic press(input bit right);
        if (right) bus.btn_right = 1'b1;
        else       bus.btn_left  = 1'b1;
        tick(10);
        bus.btn_right = 1'b0;
        bus.btn_left  = 1'b0;
        tick(10);
    endtask

    initial begin
        int first;
        checks        = 0;
        failures      = 0;
        reset         = 1'b0;
        bus.prog_sw   = 1'b0;
        bus.btn_up    = 1'b0;
        bus.btn_down  = 1'b0;
        bus.btn_left  = 1'b0;
        bus.btn_right = 1'b0;

        // Per-cycle comparison against the model, sampled on the falling edge
        fork
            forever begin
                @(negedge clk);
                checks++;
                if ({bus.en_count, bus.enUP, bus.enDOWN} !== {m_field[3:0], m_up, m_dn}) begin
                    failures++;
                    $display("FAIL cycle_outputs t=%0t: got field=%0d up=%0b dn=%0b expected field=%0d up=%0b dn=%0b",
                             $time, bus.en_count, bus.enUP, bus.enDOWN, m_field, m_up, m_dn);
                end
            end
        join_none

        // Reset and entry
        tick(3);
        check("reset_en_count", 32'(bus.en_count), 0);
        check("reset_enUP", 32'(bus.enUP), 0);
        bus.prog_sw = 1'b1;
        tick(2);
        reset = 1'b1;
        first = 0;
        for (int i = 1; i <= 20; i++) begin
            tick(1);
            if (first == 0 && bus.en_count == 4'd1) first = i;
        end
        check("entry_latency", 32'(first), 7);
        check("entry_field", 32'(bus.en_count), 1);

        // Bounce filter on right
        for (int i = 0; i < 20; i++) begin
            bus.btn_right = ((i / 2) % 2 == 0);
            tick(1);
        end
        check("bounce_no_step", 32'(bus.en_count), 1);
        bus.btn_right = 1'b1;
        first = 0;
        for (int i = 1; i <= 20; i++) begin
            tick(1);
            if (first == 0 && bus.en_count != 4'd1) first = i;
        end
        check("bounce_step_latency", 32'(first), 7);
        check("bounce_field", 32'(bus.en_count), 2);
        bus.btn_right = 1'b0;
        tick(10);

        // Wrap-around
        press(1'b0);
        check("left_2_to_1", 32'(bus.en_count), 1);
        repeat (8) press(1'b1);
        check("right_8_to_9", 32'(bus.en_count), 9);
        press(1'b1);
        check("right_wrap_to_1", 32'(bus.en_count), 1);
        press(1'b0);
        check("left_wrap_to_9", 32'(bus.en_count), 9);
        repeat (3) press(1'b0);
        check("left_to_6", 32'(bus.en_count), 6);
        bus.btn_left  = 1'b1;
        bus.btn_right = 1'b1;
        tick(10);
        check("left_right_same_cycle", 32'(bus.en_count), 6);
        bus.btn_left  = 1'b0;
        bus.btn_right = 1'b0;
        tick(10);

        // Up/down exclusivity
        bus.btn_up = 1'b1;
        tick(10);
        check("up_enUP", 32'(bus.enUP), 1);
        check("up_enDOWN", 32'(bus.enDOWN), 0);
        bus.btn_down = 1'b1;
        tick(10);
        check("both_enUP", 32'(bus.enUP), 0);
        check("both_enDOWN", 32'(bus.enDOWN), 0);
        bus.btn_up = 1'b0;
        tick(10);
        check("down_enDOWN", 32'(bus.enDOWN), 1);
        check("down_enUP", 32'(bus.enUP), 0);
        bus.btn_down = 1'b0;
        tick(10);
        check("release_enDOWN", 32'(bus.enDOWN), 0);

        // Exit priority over same-cycle right pulse
        bus.btn_up = 1'b1;
        tick(10);
        check("exit_pre_enUP", 32'(bus.enUP), 1);
        bus.prog_sw   = 1'b0;
        bus.btn_right = 1'b1;
        first = 0;
        for (int i = 1; i <= 20; i++) begin
            tick(1);
            if (first == 0 && bus.en_count != 4'd6) begin
                first = i;
                check("exit_en_count", 32'(bus.en_count), 0);
                check("exit_enUP", 32'(bus.enUP), 0);
            end
        end
        check("exit_latency", 32'(first), 7);
        bus.btn_right = 1'b0;
        bus.btn_up    = 1'b0;
        tick(10);

        // Reset mid-adjust
        bus.prog_sw = 1'b1;
        tick(12);
        check("reenter_field", 32'(bus.en_count), 1);
        repeat (5) press(1'b1);
        check("reenter_to_6", 32'(bus.en_count), 6);
        bus.btn_up = 1'b1;
        tick(10);
        check("pre_reset_enUP", 32'(bus.enUP), 1);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("async_reset_en_count", 32'(bus.en_count), 0);
        check("async_reset_enUP", 32'(bus.enUP), 0);
        tick(3);
        reset = 1'b1;
        tick(15);
        check("post_reset_field", 32'(bus.en_count), 1);
        bus.btn_up  = 1'b0;
        bus.prog_sw = 1'b0;
        tick(10);
        check("final_idle", 32'(bus.en_count), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
